// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared types and defaults for the encoder pipeline controller
// Optional feature macro: ENC_SYMBOL_COUNT_EN (per-frame symbol counter).
package enc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } enc_state_t;

    localparam int DEF_PIPE_DEPTH   = 3;
    localparam int DEF_FLUSH_CYCLES = 2;
    localparam int DEF_CNT_WIDTH    = 24;

`ifdef ENC_SYMBOL_COUNT_EN
    localparam bit SYM_CNT_EN = 1'b1;
    localparam int SYM_CNT_W  = DEF_CNT_WIDTH;
`else
    localparam bit SYM_CNT_EN = 1'b0;
    localparam int SYM_CNT_W  = 0;
`endif

    // Width of a counter that walks 0 .. n-1; never narrower than one bit.
    function automatic int flush_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/encoder_pipe_ctrl_if.sv
// rtl/encoder_pipe_ctrl_if.sv - upstream request / downstream result handshake bundle
interface encoder_pipe_ctrl_if;

    logic in_valid;
    logic in_last;
    logic in_ready;
    logic out_valid;
    logic out_ready;

    modport master (
        output in_valid,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid
    );

endinterface

// File: rtl/enc_valid_pipe.sv
// rtl/enc_valid_pipe.sv - occupancy shift register that moves in lock-step with the stage enables
module enc_valid_pipe #(
    parameter int PIPE_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  adv,
    input  logic                  in_bit,
    output logic [PIPE_DEPTH-1:0] valid
);

    generate
        if (PIPE_DEPTH == 1) begin : g_single
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid <= '0;
                end else if (adv) begin
                    valid <= in_bit;
                end
            end
        end else begin : g_multi
            // Bubbles shift alongside data so every stage sees the same enable.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid <= '0;
                end else if (adv) begin
                    valid <= {valid[PIPE_DEPTH-2:0], in_bit};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/encoder_pipe_ctrl.sv
// rtl/encoder_pipe_ctrl.sv - frame sequencer for the registered range/low encoder pipeline
// Optional feature macro: ENC_SYMBOL_COUNT_EN builds the saturating symbol counter.
module encoder_pipe_ctrl
    import enc_pkg::*;
#(
    parameter int PIPE_DEPTH   = DEF_PIPE_DEPTH,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    encoder_pipe_ctrl_if.slave    hs,
    output logic [PIPE_DEPTH-1:0] stage_en,
    output logic [PIPE_DEPTH-1:0] stage_valid,
    output logic                  flush_en,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  symbol_count
);

    localparam int                FC_W    = flush_cnt_w(FLUSH_CYCLES);
    localparam logic [FC_W-1:0]   FC_LAST = FC_W'(FLUSH_CYCLES - 1);

    enc_state_t      state;
    enc_state_t      state_nxt;
    logic [FC_W-1:0] flush_cnt;
    logic            adv;
    logic            accept;
    logic            pipe_empty;
    logic            flush_last;

    // The last stage is the only place a stall can originate.
    assign adv        = ~stage_valid[PIPE_DEPTH-1] | hs.out_ready;
    assign stage_en   = {PIPE_DEPTH{adv}};
    assign accept     = hs.in_valid & hs.in_ready;
    assign pipe_empty = ~|stage_valid;
    assign flush_last = hs.out_ready && (flush_cnt == FC_LAST);

    assign hs.out_valid = stage_valid[PIPE_DEPTH-1];

    enc_valid_pipe #(
        .PIPE_DEPTH (PIPE_DEPTH)
    ) u_valid_pipe (
        .clk    (clk),
        .reset  (reset),
        .adv    (adv),
        .in_bit (accept),
        .valid  (stage_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = hs.in_last ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && hs.in_last) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        hs.in_ready = 1'b0;
        flush_en    = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                hs.in_ready = adv;
                busy        = 1'b0;
            end
            ST_RUN: begin
                hs.in_ready = adv;
            end
            ST_FLUSH: begin
                flush_en = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                hs.in_ready = 1'b0;
            end
        endcase
    end

    // Only cycles the packer actually takes count toward the flush length.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_cnt <= '0;
        end else if (state == ST_FLUSH) begin
            if (flush_last) begin
                flush_cnt <= '0;
            end else if (hs.out_ready) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end else begin
            flush_cnt <= '0;
        end
    end

`ifdef ENC_SYMBOL_COUNT_EN
    logic [CNT_WIDTH-1:0] sym_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sym_cnt <= '0;
        end else if (accept) begin
            if (state == ST_IDLE) begin
                sym_cnt <= CNT_WIDTH'(1);
            end else if (~&sym_cnt) begin
                sym_cnt <= sym_cnt + 1'b1;
            end
        end
    end

    assign symbol_count = sym_cnt;
`else
    assign symbol_count = '0;
`endif

endmodule

// File: tb/tb_encoder_pipe_ctrl.sv
// tb/tb_encoder_pipe_ctrl.sv - directed self-checking bench for encoder_pipe_ctrl
module tb_encoder_pipe_ctrl;
    import enc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  stage_en;
    logic [2:0]  stage_valid;
    logic        flush_en;
    logic        busy;
    logic        done;
    logic [23:0] symbol_count;

    int n_checks = 0;
    int n_pass   = 0;
    int acc_cnt  = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;

    logic [10:0] seq[$];

    always #5 clk = ~clk;

    encoder_pipe_ctrl_if hs ();

    encoder_pipe_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .hs           (hs),
        .stage_en     (stage_en),
        .stage_valid  (stage_valid),
        .flush_en     (flush_en),
        .busy         (busy),
        .done         (done),
        .symbol_count (symbol_count)
    );

    // {in_ready, out_valid, flush_en, busy, done, stage_valid[2:0]}
    wire [7:0] status = {hs.in_ready, hs.out_valid, flush_en, busy, done, stage_valid};

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step(input string tag, input bit iv, input bit il, input bit ordy, input logic [7:0] exp);
        hs.in_valid  = iv;
        hs.in_last   = il;
        hs.out_ready = ordy;
        @(negedge clk);
        check_eq(tag, 32'(status), 32'(exp));
        if (hs.in_valid && hs.in_ready) acc_cnt++;
        if (hs.out_valid && hs.out_ready) xfer_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input string name);
        foreach (seq[i]) begin
            step($sformatf("%s_c%0d", name, i), seq[i][10], seq[i][9], seq[i][8], seq[i][7:0]);
        end
        seq.delete();
    endtask

    initial begin
        hs.in_valid  = 1'b0;
        hs.in_last   = 1'b0;
        hs.out_ready = 1'b1;
        reset        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_status", 32'(status), 32'h80);
        check_eq("rst_stage_en", 32'(stage_en), 32'h7);
        check_eq("rst_symcnt", 32'(symbol_count), 32'h0);
        reset = 1'b1;

        // Five back-to-back symbols, last on the fifth.
        acc_cnt = 0; xfer_cnt = 0;
        seq = '{{3'b101, 8'h80}, {3'b101, 8'h91}, {3'b101, 8'h93}, {3'b101, 8'hD7},
                {3'b111, 8'hD7}, {3'b001, 8'h57}, {3'b001, 8'h56}, {3'b001, 8'h54},
                {3'b001, 8'h10}, {3'b001, 8'h30}, {3'b001, 8'h30}, {3'b001, 8'h18},
                {3'b001, 8'h80}};
        run_seq("burst5");
        check_eq("burst5_acc", 32'(acc_cnt), 32'd5);
        check_eq("burst5_xfer", 32'(xfer_cnt), 32'd5);
        check_eq("burst5_symcnt", 32'(symbol_count), SYM_CNT_EN ? 32'd5 : 32'd0);

        // Single symbol marked last straight from IDLE.
        acc_cnt = 0; xfer_cnt = 0;
        seq = '{{3'b111, 8'h80}, {3'b001, 8'h11}, {3'b001, 8'h12}, {3'b001, 8'h54},
                {3'b001, 8'h10}, {3'b001, 8'h30}, {3'b001, 8'h30}, {3'b001, 8'h18},
                {3'b001, 8'h80}};
        run_seq("single");
        check_eq("single_xfer", 32'(xfer_cnt), 32'd1);
        check_eq("single_symcnt", 32'(symbol_count), SYM_CNT_EN ? 32'd1 : 32'd0);

        // Full pipeline, downstream stalls four cycles.
        acc_cnt = 0; xfer_cnt = 0;
        seq = '{{3'b101, 8'h80}, {3'b101, 8'h91}, {3'b101, 8'h93}, {3'b100, 8'h57}};
        run_seq("stall_a");
        check_eq("stall_stage_en", 32'(stage_en), 32'h0);
        seq = '{{3'b100, 8'h57}, {3'b100, 8'h57}, {3'b100, 8'h57}, {3'b111, 8'hD7},
                {3'b001, 8'h57}, {3'b001, 8'h56}, {3'b001, 8'h54}, {3'b001, 8'h10},
                {3'b001, 8'h30}, {3'b001, 8'h30}, {3'b001, 8'h18}, {3'b001, 8'h80}};
        run_seq("stall_b");
        check_eq("stall_acc", 32'(acc_cnt), 32'd4);
        check_eq("stall_xfer", 32'(xfer_cnt), 32'd4);
        check_eq("stall_symcnt", 32'(symbol_count), SYM_CNT_EN ? 32'd4 : 32'd0);

        // Downstream stalls after the first flush cycle.
        acc_cnt = 0; xfer_cnt = 0;
        seq = '{{3'b111, 8'h80}, {3'b001, 8'h11}, {3'b001, 8'h12}, {3'b001, 8'h54},
                {3'b001, 8'h10}, {3'b001, 8'h30}, {3'b000, 8'h30}, {3'b000, 8'h30},
                {3'b001, 8'h30}, {3'b001, 8'h18}, {3'b001, 8'h80}};
        run_seq("flush_stall");

        // in_valid held high across DRAIN/FLUSH/DONE, then a new frame opens.
        acc_cnt = 0; xfer_cnt = 0;
        seq = '{{3'b111, 8'h80}, {3'b101, 8'h11}, {3'b101, 8'h12}, {3'b101, 8'h54},
                {3'b101, 8'h10}, {3'b101, 8'h30}, {3'b101, 8'h30}, {3'b101, 8'h18},
                {3'b101, 8'h80}, {3'b101, 8'h91}};
        run_seq("hold_iv");
        check_eq("hold_iv_acc", 32'(acc_cnt), 32'd3);
        check_eq("abort_pre", 32'(status), 32'h93);
        check_eq("abort_pre_symcnt", 32'(symbol_count), SYM_CNT_EN ? 32'd2 : 32'd0);

        // Reset dropped mid-cycle while RUN holds two symbols.
        #2;
        reset = 1'b0;
        #1;
        check_eq("abort_status", 32'(status), 32'h80);
        check_eq("abort_symcnt", 32'(symbol_count), 32'h0);
        @(posedge clk);
        #1;
        seq = '{{3'b101, 8'h80}, {3'b101, 8'h80}};
        run_seq("abort_hold");
        reset = 1'b1;
        seq = '{{3'b001, 8'h80}, {3'b001, 8'h80}};
        run_seq("abort_after");
        check_eq("done_pulses", 32'(done_cnt), 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/encoder_pipe_ctrl.md
ENCODER_PIPE_CTRL -- requirements
Module: encoder_pipe_ctrl

Interface
REQ-001 SHALL have parameter PIPE_DEPTH, default 3, number of registered encoder stages sequenced.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, number of end-of-frame flush cycles.
REQ-003 SHALL have parameter CNT_WIDTH, default 24, width of the symbol counter.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  upstream symbol/bool request valid.
REQ-007 SHALL have port in_last  input  1  qualifies in_valid; marks the final symbol of a frame.
REQ-008 SHALL have port in_ready  output  1  controller accepts the request this cycle.
REQ-009 SHALL have port stage_en  output  PIPE_DEPTH  per-stage register load enable.
REQ-010 SHALL have port stage_valid  output  PIPE_DEPTH  per-stage occupancy flag.
REQ-011 SHALL have port out_valid  output  1  last stage holds a normalized range/low result.
REQ-012 SHALL have port out_ready  input  1  downstream bitstream packer accepts.
REQ-013 SHALL have port flush_en  output  1  drives final-bits flush logic.
REQ-014 SHALL have port busy  output  1  frame in progress (any state except IDLE).
REQ-015 SHALL have port done  output  1  one-cycle end-of-frame pulse.
REQ-016 SHALL have port symbol_count  output  CNT_WIDTH  symbols accepted this frame (macro-gated, REQ-033).

Function
REQ-017 SHALL compute adv = !stage_valid[PIPE_DEPTH-1] | out_ready, combinationally.
REQ-018 SHALL drive every stage_en bit equal to adv; bubbles advance with data.
REQ-019 SHALL, when adv, load stage_valid[0] <= accept and stage_valid[i] <= stage_valid[i-1]; hold otherwise.
REQ-020 SHALL define accept = in_valid & in_ready; in_ready = adv & (state is IDLE or RUN).
REQ-021 SHALL drive out_valid = stage_valid[PIPE_DEPTH-1]; with no stalls, a symbol accepted at edge k gives out_valid high after edge k+PIPE_DEPTH-1.
REQ-022 SHALL implement FSM IDLE, RUN, DRAIN, FLUSH, DONE.
REQ-023 IDLE: accept & !in_last -> RUN; accept & in_last -> DRAIN.
REQ-024 RUN: accept & in_last -> DRAIN; else stay.
REQ-025 DRAIN: in_ready=0, bubbles only; when stage_valid all zero -> FLUSH.
REQ-026 FLUSH: flush_en=1 for FLUSH_CYCLES cycles in which out_ready=1 (counter holds when out_ready=0); then -> DONE.
REQ-027 DONE: done=1 for exactly one cycle, in_ready=0; -> IDLE.
REQ-028 SHALL ignore in_valid in DRAIN, FLUSH, DONE (no acceptance, no state change).
REQ-029 out_ready low in DRAIN SHALL freeze the pipeline and extend DRAIN without loss.
REQ-030 flush_en and out_valid SHALL never be high in the same cycle.

Reset
REQ-031 On reset low: state=IDLE; stage_valid=0; flush counter=0; symbol_count=0; out_valid, flush_en, busy, done=0; in_ready follows REQ-020 (=1).
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately; no done pulse is generated.

Configuration
REQ-033 With ENC_SYMBOL_COUNT_EN defined: symbol_count loads 1 on accept in IDLE, increments on accept in RUN, saturates at all-ones, holds otherwise; without it the port remains and is tied to 0, and no counter is built.

Structure
REQ-034 State encoding typedef, default parameter constants, and the ENC_SYMBOL_COUNT_EN-dependent counter width SHALL reside in shared package enc_pkg.
REQ-035 Valid shift register SHALL be sub-module enc_valid_pipe (PIPE_DEPTH, adv, in bit, valid vector); FSM and counters stay top-level.

Verification
REQ-036 Reset, then 5 back-to-back symbols with last on 5th, out_ready=1 -> out_valid high 5 consecutive cycles starting 2 cycles after first accept, flush_en 2 cycles, then done 1 cycle, busy drops.
REQ-037 Single symbol with in_last in IDLE -> direct IDLE->DRAIN, one out_valid, 2 flush cycles, done; symbol_count=1 (macro on).
REQ-038 Full pipeline, out_ready=0 for 4 cycles -> in_ready=0, stage_valid frozen at 3'b111, no data lost on release.
REQ-039 out_ready=0 during FLUSH after first flush cycle -> flush_en held, flush count completes only after 2 out_ready-high cycles.
REQ-040 in_valid held high through DRAIN/FLUSH/DONE -> zero acceptances; next frame accepted only in IDLE.
REQ-041 reset low in RUN with stage_valid=3'b011 -> all outputs zero asynchronously, no done; macro off -> symbol_count constantly 0.
